// File: rtl/avmm_cmd_arbiter_if.sv
// ---------------------------------------------------------------------------
// avmm_cmd_arbiter_if
//   Avalon-MM bursting command/response bundle, shared by requester-side and
//   downstream-side ports of avmm_cmd_arbiter.
//
//   master modport : drives write/read/address/writedata/burstcount,
//                    receives waitrequest/readdata/readdatavalid.
//   slave modport  : the mirror image.
//
//   The default widths match ccip_avmm_pkg (declared in avmm_cmd_arbiter.sv).
// ---------------------------------------------------------------------------
interface avmm_cmd_arbiter_if #(
    parameter int DW = 64,
    parameter int AW = 32,
    parameter int BW = 4
);
    logic          write;
    logic          read;
    logic [AW-1:0] address;
    logic [DW-1:0] writedata;
    logic [BW-1:0] burstcount;
    logic          waitrequest;
    logic [DW-1:0] readdata;
    logic          readdatavalid;

    modport master (
        output write, read, address, writedata, burstcount,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  write, read, address, writedata, burstcount,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/avmm_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// ccip_avmm_pkg / avmm_cmd_arbiter
//   Two-requester Avalon-MM command arbiter with read-response routing.
//
//   Ports
//     clk            : single clock, rising edge
//     reset          : synchronous, active-high
//     m0_avmm        : requester 0 (slave modport)
//     m1_avmm        : requester 1 (slave modport)
//     out_avmm       : shared downstream command/response (master modport)
//     rsp_orphan_err : sticky, a response beat arrived with no read outstanding
//
//   Parameter
//     RD_TAG_DEPTH   : outstanding read bursts tracked (power of 2, >= 2)
//
//   Build option
//     AVMM_ARB_FIXED_PRIORITY_EN : when defined, requester 0 wins every tie;
//                                  otherwise ties are broken round-robin.
//
//   A granted write keeps the grant for its whole burst; a granted read
//   releases it as soon as the command is accepted and records {id, burst}
//   in a tag FIFO. Response beats are steered to the requester at the FIFO
//   head with no added latency.
// ---------------------------------------------------------------------------
package ccip_avmm_pkg;
    localparam int CCIP_AVMM_REQUESTOR_DATA_WIDTH  = 64;
    localparam int CCIP_AVMM_REQUESTOR_ADDR_WIDTH  = 32;
    localparam int CCIP_AVMM_REQUESTOR_BURST_WIDTH = 4;
endpackage

module avmm_cmd_arbiter
    import ccip_avmm_pkg::*;
#(
    parameter int RD_TAG_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    avmm_cmd_arbiter_if.slave    m0_avmm,
    avmm_cmd_arbiter_if.slave    m1_avmm,
    avmm_cmd_arbiter_if.master   out_avmm,
    output logic                 rsp_orphan_err
);
    localparam int DW = CCIP_AVMM_REQUESTOR_DATA_WIDTH;
    localparam int AW = CCIP_AVMM_REQUESTOR_ADDR_WIDTH;
    localparam int BW = CCIP_AVMM_REQUESTOR_BURST_WIDTH;
    localparam int PW = $clog2(RD_TAG_DEPTH);
    localparam int TW = 1 + BW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_wr_active;      // first beat of the current write burst taken
    logic [BW-1:0]   r_wr_left;        // beats still owed after the first one
    logic [PW:0]     r_wr_ptr;
    logic [PW:0]     r_rd_ptr;
    logic [TW-1:0]   r_tag_mem [RD_TAG_DEPTH];
    logic [BW-1:0]   r_rsp_cnt;        // beats already returned for the head tag
    logic            r_orphan;
`ifndef AVMM_ARB_FIXED_PRIORITY_EN
    logic            r_last_grant;
`endif

    logic            w_g0;
    logic            w_g1;
    logic            w_any0;
    logic            w_any1;
    logic            w_pick1;
    logic            w_sel_write;
    logic            w_sel_read;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;
    logic [BW-1:0]   w_sel_bc;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic            w_rd_block;
    logic            w_out_read;
    logic            w_wait;
    logic            w_wr_acc;
    logic            w_rd_acc;
    logic            w_wr_last;
    logic [TW-1:0]   w_head;
    logic            w_head_id;
    logic [BW-1:0]   w_head_bc;
    logic            w_rsp_beat;
    logic            w_rsp_last;
    logic            w_pop;

    // Grant decode is masked by reset so the bus is quiet from the very first
    // reset cycle, before the state register has been cleared.
    assign w_g0 = (r_state == GRANT0) && !reset;
    assign w_g1 = (r_state == GRANT1) && !reset;

    assign w_any0 = m0_avmm.write | m0_avmm.read;
    assign w_any1 = m1_avmm.write | m1_avmm.read;

`ifdef AVMM_ARB_FIXED_PRIORITY_EN
    assign w_pick1 = w_any1 && !w_any0;
`else
    // Tie goes to whoever was not served last.
    assign w_pick1 = w_any1 && (!w_any0 || !r_last_grant);
`endif

    // ---------------- command path ----------------
    assign w_sel_write = w_g0 ? m0_avmm.write : (w_g1 ? m1_avmm.write : 1'b0);
    assign w_sel_read  = w_g0 ? m0_avmm.read  : (w_g1 ? m1_avmm.read  : 1'b0);
    assign w_sel_addr  = w_g1 ? m1_avmm.address    : m0_avmm.address;
    assign w_sel_data  = w_g1 ? m1_avmm.writedata  : m0_avmm.writedata;
    assign w_sel_bc    = w_g1 ? m1_avmm.burstcount : m0_avmm.burstcount;

    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                          (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

    // A read is held off while the tag FIFO is full (no credit for its
    // response) or while a write burst is mid-flight; write takes precedence
    // if a requester raises both.
    assign w_rd_block = w_sel_read && !w_sel_write && (w_fifo_full || r_wr_active);
    assign w_out_read = w_sel_read && !w_sel_write && !w_fifo_full && !r_wr_active;
    assign w_wait     = out_avmm.waitrequest | w_rd_block;

    assign out_avmm.write      = w_sel_write;
    assign out_avmm.read       = w_out_read;
    assign out_avmm.address    = w_sel_addr;
    assign out_avmm.writedata  = w_sel_data;
    assign out_avmm.burstcount = w_sel_bc;

    assign m0_avmm.waitrequest = w_g0 ? w_wait : 1'b1;
    assign m1_avmm.waitrequest = w_g1 ? w_wait : 1'b1;

    assign w_wr_acc  = w_sel_write && !out_avmm.waitrequest;
    assign w_rd_acc  = w_out_read  && !out_avmm.waitrequest;
    // burstcount of 0 is illegal; treat it like a single beat so the grant
    // can never lock up.
    assign w_wr_last = w_wr_acc && (r_wr_active ? (r_wr_left == BW'(1))
                                                : (w_sel_bc <= BW'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wr_active <= 1'b0;
            r_wr_left   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wr_active <= 1'b0;
                    if (w_any0 || w_any1)
                        r_state <= w_pick1 ? GRANT1 : GRANT0;
                end
                GRANT0, GRANT1: begin
                    if (w_wr_acc) begin
                        if (w_wr_last) begin
                            r_state     <= IDLE;
                            r_wr_active <= 1'b0;
                        end else if (!r_wr_active) begin
                            r_wr_active <= 1'b1;
                            r_wr_left   <= w_sel_bc - 1'b1;
                        end else begin
                            r_wr_left   <= r_wr_left - 1'b1;
                        end
                    end else if (w_rd_acc) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifndef AVMM_ARB_FIXED_PRIORITY_EN
    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (reset)
            r_last_grant <= 1'b1;
        else if (w_wr_last || w_rd_acc)
            r_last_grant <= w_g1;
    end
`endif

    // ---------------- read tag FIFO ----------------
    // Kept small and read asynchronously: the head tag must steer a response
    // beat in the same cycle it arrives.
    always_ff @(posedge clk) begin
        if (w_rd_acc)
            r_tag_mem[r_wr_ptr[PW-1:0]] <= {w_g1, w_sel_bc};
    end

    assign w_head    = r_tag_mem[r_rd_ptr[PW-1:0]];
    assign w_head_id = w_head[BW];
    assign w_head_bc = w_head[BW-1:0];

    assign w_rsp_beat = out_avmm.readdatavalid && !w_fifo_empty && !reset;
    assign w_rsp_last = (r_rsp_cnt + 1'b1 == w_head_bc) || (w_head_bc == '0);
    assign w_pop      = w_rsp_beat && w_rsp_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rsp_cnt <= '0;
            r_orphan  <= 1'b0;
        end else begin
            if (w_rd_acc)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_rsp_beat)
                r_rsp_cnt <= w_rsp_last ? '0 : r_rsp_cnt + 1'b1;
            if (out_avmm.readdatavalid && w_fifo_empty)
                r_orphan <= 1'b1;
        end
    end

    // ---------------- response path ----------------
    assign m0_avmm.readdata      = out_avmm.readdata;
    assign m1_avmm.readdata      = out_avmm.readdata;
    assign m0_avmm.readdatavalid = w_rsp_beat && !w_head_id;
    assign m1_avmm.readdatavalid = w_rsp_beat &&  w_head_id;

    assign rsp_orphan_err = r_orphan;

endmodule
